// File: rtl/buzzer_sched_if.sv
// rtl/buzzer_sched_if.sv - request/grant and buzzer bus for buzzer_sched
// Purpose: bundles the requester handshake, status and piezo drive of buzzer_sched.
// Signals:
//   req        3   request level per requester (held until its gnt bit is seen)
//   note_in   12   {note2,note1,note0}, 4 bits each
//   dur_in    24   {dur2,dur1,dur0}, 8 bits each, in ms
//   gnt        3   one-hot, single-cycle grant
//   busy       1   a note or its trailing gap is in progress
//   active_id  2   index of the granted requester
//   done       1   single-cycle end-of-note pulse
//   sp         1   buzzer drive
// Modports: master = requester side, slave = scheduler side.
interface buzzer_sched_if;
    logic [2:0]  req;
    logic [11:0] note_in;
    logic [23:0] dur_in;
    logic [2:0]  gnt;
    logic        busy;
    logic [1:0]  active_id;
    logic        done;
    logic        sp;

    modport master (
        output req, note_in, dur_in,
        input  gnt, busy, active_id, done, sp
    );

    modport slave (
        input  req, note_in, dur_in,
        output gnt, busy, active_id, done, sp
    );
endinterface

// File: rtl/buzzer_sched.sv
// rtl/buzzer_sched.sv - priority scheduler sharing one piezo buzzer between 3 requesters
// Purpose: grants the lowest-index pending request, plays its note for dur ms using a
//   note ROM and half-period divider, then holds a silent gap before the next grant.
// Ports:
//   clk  in   system clock, all logic on posedge
//   rst  in   synchronous reset, active-high
//   bus  slave modport of buzzer_sched_if (req/note_in/dur_in in; gnt/busy/active_id/done/sp out)
// Parameters: CLK_HZ (clock frequency), GAP_MS (silent gap after each note, 0 = none).
// Option macro PREEMPT_EN: a higher-priority request aborts the note or gap in progress.
module buzzer_sched #(
    parameter int unsigned CLK_HZ = 25000000,
    parameter int unsigned GAP_MS = 20
) (
    input  logic          clk,
    input  logic          rst,
    buzzer_sched_if.slave bus
);

    localparam int unsigned MS_CYC  = CLK_HZ / 1000;
    localparam int unsigned GAP_CYC = GAP_MS * MS_CYC;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_GAP
    } state_t;

    state_t      state_q;
    logic [31:0] rem_q;      // cycles left in PLAY or GAP, counting the current one
    logic [31:0] tc_q;       // tone half-period counter
    logic [31:0] hp_q;       // half-period of the latched note, 0 = rest
    logic        sp_q;
    logic        zdone_q;    // done pulse owed for a zero-length note
    logic [1:0]  active_q;

    logic [2:0]  cand;
    logic        sel_valid;
    logic [1:0]  sel_id;
    logic [3:0]  sel_note;
    logic [7:0]  sel_dur;
    logic        grant_fire;
    logic        preempt_fire;

    // Half-period in clk cycles; frequencies in mHz (equal temperament from A4 = 440 Hz).
    function automatic logic [31:0] note_hp(input logic [3:0] n);
        logic [63:0] f_mhz;
        case (n)
            4'd1:    f_mhz = 64'd440000;
            4'd2:    f_mhz = 64'd466164;
            4'd3:    f_mhz = 64'd493883;
            4'd4:    f_mhz = 64'd523251;
            4'd5:    f_mhz = 64'd554365;
            4'd6:    f_mhz = 64'd587330;
            4'd7:    f_mhz = 64'd622254;
            4'd8:    f_mhz = 64'd659255;
            4'd9:    f_mhz = 64'd698456;
            4'd10:   f_mhz = 64'd739989;
            4'd11:   f_mhz = 64'd783991;
            4'd12:   f_mhz = 64'd830609;
            default: f_mhz = 64'd0;
        endcase
        if (f_mhz == 64'd0) begin
            return 32'd0;
        end
        return 32'((64'(CLK_HZ) * 64'd1000) / (64'd2 * f_mhz));
    endfunction

    always_comb begin
        cand = 3'b000;
        if (state_q == S_IDLE) begin
            cand = bus.req;
        end
`ifdef PREEMPT_EN
        else begin
            // Only strictly higher-priority requesters may abort the current note.
            case (active_q)
                2'd1:    cand = bus.req & 3'b001;
                2'd2:    cand = bus.req & 3'b011;
                default: cand = 3'b000;
            endcase
        end
`endif
        sel_valid = |cand;
        if (cand[0]) begin
            sel_id = 2'd0;
        end else if (cand[1]) begin
            sel_id = 2'd1;
        end else begin
            sel_id = 2'd2;
        end
        case (sel_id)
            2'd0: begin
                sel_note = bus.note_in[3:0];
                sel_dur  = bus.dur_in[7:0];
            end
            2'd1: begin
                sel_note = bus.note_in[7:4];
                sel_dur  = bus.dur_in[15:8];
            end
            default: begin
                sel_note = bus.note_in[11:8];
                sel_dur  = bus.dur_in[23:16];
            end
        endcase
        grant_fire   = sel_valid && !rst;
        preempt_fire = grant_fire && (state_q != S_IDLE);
    end

    // gnt and the abort done are combinational so they land in the same cycle the request is taken.
    assign bus.gnt       = grant_fire ? (3'b001 << sel_id) : 3'b000;
    assign bus.done      = !rst && (((state_q == S_PLAY) && (rem_q == 32'd1)) || zdone_q || preempt_fire);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.active_id = active_q;
    assign bus.sp        = sp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rem_q    <= 32'd0;
            tc_q     <= 32'd0;
            hp_q     <= 32'd0;
            sp_q     <= 1'b0;
            zdone_q  <= 1'b0;
            active_q <= 2'd0;
        end else begin
            zdone_q <= 1'b0;
            if (grant_fire) begin
                active_q <= sel_id;
                hp_q     <= note_hp(sel_note);
                tc_q     <= 32'd0;
                sp_q     <= 1'b0;
                if (sel_dur == 8'd0) begin
                    // Nothing to play: owe the done pulse next cycle and go straight to the gap.
                    zdone_q <= 1'b1;
                    rem_q   <= GAP_CYC;
                    state_q <= (GAP_MS == 0) ? S_IDLE : S_GAP;
                end else begin
                    rem_q   <= 32'(sel_dur) * MS_CYC;
                    state_q <= S_PLAY;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        sp_q <= 1'b0;
                    end
                    S_PLAY: begin
                        if (rem_q <= 32'd1) begin
                            sp_q    <= 1'b0;
                            tc_q    <= 32'd0;
                            rem_q   <= GAP_CYC;
                            state_q <= (GAP_MS == 0) ? S_IDLE : S_GAP;
                        end else begin
                            rem_q <= rem_q - 32'd1;
                            if (hp_q != 32'd0) begin
                                if (tc_q == hp_q - 32'd1) begin
                                    tc_q <= 32'd0;
                                    sp_q <= ~sp_q;
                                end else begin
                                    tc_q <= tc_q + 32'd1;
                                end
                            end
                        end
                    end
                    S_GAP: begin
                        sp_q <= 1'b0;
                        if (rem_q <= 32'd1) begin
                            rem_q   <= 32'd0;
                            state_q <= S_IDLE;
                        end else begin
                            rem_q <= rem_q - 32'd1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_buzzer_sched.sv
// tb/tb_buzzer_sched.sv - self-checking bench for buzzer_sched
module tb_buzzer_sched;

    localparam int K_GNT   = 0;
    localparam int K_DONE  = 1;
    localparam int K_SP    = 2;
    localparam int K_BFALL = 3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] cyc;
        logic [7:0]  val;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    ev_t  exp_q[$];
    ev_t  obs_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    buzzer_sched_if bif ();

    buzzer_sched #(
        .CLK_HZ(1000000),
        .GAP_MS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    function automatic ev_t mk(input int k, input int c, input int v);
        ev_t e;
        e.kind = k[1:0];
        e.cyc  = c;
        e.val  = v[7:0];
        return e;
    endfunction

    // Records DUT events for n cycles; a granted requester drops its req after the grant edge.
    task automatic collect(input int n);
        logic       prev_sp;
        logic       prev_busy;
        logic [2:0] drop;
        prev_sp   = bif.sp;
        prev_busy = bif.busy;
        drop      = 3'b000;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bif.gnt != 3'b000) begin
                obs_q.push_back(mk(K_GNT, cyc, int'(bif.gnt)));
                drop = bif.gnt;
            end
            if (bif.done) obs_q.push_back(mk(K_DONE, cyc, int'(bif.active_id)));
            if (bif.sp !== prev_sp) obs_q.push_back(mk(K_SP, cyc, int'(bif.sp)));
            if (prev_busy && !bif.busy) obs_q.push_back(mk(K_BFALL, cyc, 0));
            prev_sp   = bif.sp;
            prev_busy = bif.busy;
            @(posedge clk);
            #1;
            bif.req = bif.req & ~drop;
            drop    = 3'b000;
        end
    endtask

    task automatic test_reset();
        bif.req = 3'b111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (bif.gnt !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_gnt: got %b want 000", bif.gnt);
            end
            n_checks++;
            if (bif.sp !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_sp: got %b want 0", bif.sp);
            end
            n_checks++;
            if (bif.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_busy: got %b want 0", bif.busy);
            end
            n_checks++;
            if (bif.done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_done: got %b want 0", bif.done);
            end
        end
        @(posedge clk);
        #1;
        bif.req = 3'b000;
        rst     = 1'b0;
    endtask

    task automatic test_tone();
        ev_t e, o;
        int  g;
        bif.note_in = {4'd0, 4'd1, 4'd0};
        bif.dur_in  = {8'd0, 8'd3, 8'd0};
        bif.req     = 3'b010;
        g = cyc;
        exp_q.push_back(mk(K_GNT, g, 2));
        exp_q.push_back(mk(K_SP, g + 1137, 1));
        exp_q.push_back(mk(K_SP, g + 2273, 0));
        exp_q.push_back(mk(K_DONE, g + 3000, 1));
        exp_q.push_back(mk(K_BFALL, g + 5001, 0));
        collect(5010);
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            n_checks++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL tone_count: observed left %0d, expected left %0d", obs_q.size(), exp_q.size());
                exp_q.delete();
                obs_q.delete();
            end else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL tone_event: got kind %0d cyc %0d val %0d, want kind %0d cyc %0d val %0d",
                             o.kind, o.cyc, o.val, e.kind, e.cyc, e.val);
                end
            end
        end
    endtask

    task automatic test_priority();
        ev_t e, o;
        int  g;
        bif.note_in = 12'h000;
        bif.dur_in  = {8'd1, 8'd1, 8'd0};
        bif.req     = 3'b110;
        g = cyc;
        exp_q.push_back(mk(K_GNT, g, 2));
        exp_q.push_back(mk(K_DONE, g + 1000, 1));
        exp_q.push_back(mk(K_GNT, g + 3001, 4));
        exp_q.push_back(mk(K_BFALL, g + 3001, 0));
        exp_q.push_back(mk(K_DONE, g + 4001, 2));
        exp_q.push_back(mk(K_BFALL, g + 6002, 0));
        collect(6010);
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            n_checks++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL prio_count: observed left %0d, expected left %0d", obs_q.size(), exp_q.size());
                exp_q.delete();
                obs_q.delete();
            end else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL prio_event: got kind %0d cyc %0d val %0d, want kind %0d cyc %0d val %0d",
                             o.kind, o.cyc, o.val, e.kind, e.cyc, e.val);
                end
            end
        end
    endtask

    task automatic test_rest_and_zero();
        ev_t e, o;
        int  g;
        bif.note_in = 12'h000;
        bif.dur_in  = {8'd0, 8'd0, 8'd5};
        bif.req     = 3'b001;
        g = cyc;
        exp_q.push_back(mk(K_GNT, g, 1));
        exp_q.push_back(mk(K_DONE, g + 5000, 0));
        exp_q.push_back(mk(K_BFALL, g + 7001, 0));
        collect(7010);
        bif.dur_in = 24'h000000;
        bif.req    = 3'b001;
        g = cyc;
        exp_q.push_back(mk(K_GNT, g, 1));
        exp_q.push_back(mk(K_DONE, g + 1, 0));
        exp_q.push_back(mk(K_BFALL, g + 2001, 0));
        collect(2010);
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            n_checks++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL rest_count: observed left %0d, expected left %0d", obs_q.size(), exp_q.size());
                exp_q.delete();
                obs_q.delete();
            end else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL rest_event: got kind %0d cyc %0d val %0d, want kind %0d cyc %0d val %0d",
                             o.kind, o.cyc, o.val, e.kind, e.cyc, e.val);
                end
            end
        end
    endtask

    task automatic test_reset_mid_play();
        ev_t e, o;
        int  g;
        bif.note_in = {4'd1, 4'd0, 4'd0};
        bif.dur_in  = {8'd3, 8'd1, 8'd0};
        bif.req     = 3'b100;
        g = cyc;
        exp_q.push_back(mk(K_GNT, g, 4));
        exp_q.push_back(mk(K_SP, g + 1137, 1));
        collect(1200);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bif.done !== 1'b0) begin
            n_fail++;
            $display("FAIL rstplay_done0: got %b want 0", bif.done);
        end
        @(negedge clk);
        n_checks++;
        if (bif.sp !== 1'b0) begin
            n_fail++;
            $display("FAIL rstplay_sp: got %b want 0", bif.sp);
        end
        n_checks++;
        if (bif.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstplay_busy: got %b want 0", bif.busy);
        end
        n_checks++;
        if (bif.done !== 1'b0) begin
            n_fail++;
            $display("FAIL rstplay_done1: got %b want 0", bif.done);
        end
        @(posedge clk);
        #1;
        rst     = 1'b0;
        bif.req = 3'b010;
        g = cyc;
        exp_q.push_back(mk(K_GNT, g, 2));
        exp_q.push_back(mk(K_DONE, g + 1000, 1));
        exp_q.push_back(mk(K_BFALL, g + 3001, 0));
        collect(3010);
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            n_checks++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL rstplay_count: observed left %0d, expected left %0d", obs_q.size(), exp_q.size());
                exp_q.delete();
                obs_q.delete();
            end else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL rstplay_event: got kind %0d cyc %0d val %0d, want kind %0d cyc %0d val %0d",
                             o.kind, o.cyc, o.val, e.kind, e.cyc, e.val);
                end
            end
        end
    endtask

    task automatic test_preempt();
        ev_t e, o;
        int  g;
        int  p;
        bif.note_in = {4'd1, 4'd0, 4'd1};
        bif.dur_in  = {8'd3, 8'd0, 8'd1};
        bif.req     = 3'b100;
        g = cyc;
        exp_q.push_back(mk(K_GNT, g, 4));
        collect(600);
        bif.req = bif.req | 3'b001;
        p = cyc;
`ifdef PREEMPT_EN
        exp_q.push_back(mk(K_GNT, p, 1));
        exp_q.push_back(mk(K_DONE, p, 2));
        exp_q.push_back(mk(K_DONE, p + 1000, 0));
        exp_q.push_back(mk(K_BFALL, p + 3001, 0));
        collect(3010);
`else
        exp_q.push_back(mk(K_SP, g + 1137, 1));
        exp_q.push_back(mk(K_SP, g + 2273, 0));
        exp_q.push_back(mk(K_DONE, g + 3000, 2));
        exp_q.push_back(mk(K_GNT, g + 5001, 1));
        exp_q.push_back(mk(K_BFALL, g + 5001, 0));
        exp_q.push_back(mk(K_DONE, g + 6001, 0));
        exp_q.push_back(mk(K_BFALL, g + 8002, 0));
        collect(g + 8010 - p);
`endif
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            n_checks++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL preempt_count: observed left %0d, expected left %0d", obs_q.size(), exp_q.size());
                exp_q.delete();
                obs_q.delete();
            end else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL preempt_event: got kind %0d cyc %0d val %0d, want kind %0d cyc %0d val %0d",
                             o.kind, o.cyc, o.val, e.kind, e.cyc, e.val);
                end
            end
        end
    endtask

    initial begin
        bif.req     = 3'b000;
        bif.note_in = 12'h000;
        bif.dur_in  = 24'h000000;
        test_reset();
        test_tone();
        test_priority();
        test_rest_and_zero();
        test_reset_mid_play();
        test_preempt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
